divider_iterative: RTL and testbench
====================================

Name: divider_iterative

Overview:
Sequential 32-bit integer divider for the ALU M-extension path. It is the inverse-direction companion of the shift-add multiplier. It computes the quotient and remainder of DIV/DIVU/REM/REMU using a radix-2 restoring algorithm, one bit per cycle. It uses the same start/busy/valid handshake as the multiplier, so the ALU sequencer drives both blocks identically.

Parameters:
WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; accepted only when busy=0.
dividend  input  WIDTH  numerator (rs1).
divisor  input  WIDTH  denominator (rs2).
is_signed  input  1  1 = two's-complement operands (DIV/REM); 0 = unsigned (DIVU/REMU).
quotient  output  WIDTH  registered quotient.
remainder  output  WIDTH  registered remainder.
div_by_zero  output  1  registered flag, valid with the result: divisor was 0.
valid  output  1  one-cycle pulse, result ready.
busy  output  1  high from accept until the result cycle.

Behaviour:
- Reset: synchronous, active-high.
  - While rst=1 at an edge: state=IDLE, counter=0; quotient, remainder, div_by_zero, valid and busy all 0.
  - Reset mid-operation aborts the operation; no valid is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - At an edge with start=1, latch the operands and is_signed internally; later input changes are ignored.
  - Compute magnitudes |dividend| and |divisor| (two's-complement negate if is_signed and MSB set).
  - Record neg_q = is_signed & (sign_a ^ sign_b), neg_r = is_signed & sign_a, dz = (divisor==0), ovf = is_signed & dividend==0x80000000 & divisor==0xFFFFFFFF.
  - partial remainder=0, counter=0, busy<=1, valid<=0; go to CALC.
- CALC, one restoring step per edge:
  - trial = {rem[WIDTH-1:0], q[WIDTH-1]} - {0, |divisor|}.
  - If trial is non-negative: rem<=trial, shift 1 into q; else rem<=shifted value, shift 0 into q.
  - counter increments each step; after WIDTH steps (counter==WIDTH-1 at the edge) go to FIX.
- FIX (single edge):
  - quotient <= neg_q ? -q : q; remainder <= neg_r ? -rem : rem.
  - Overrides per RISC-V:
    - dz: quotient=all ones, remainder=original dividend (unsigned or signed).
    - ovf: quotient=0x80000000, remainder=0.
  - div_by_zero<=dz, valid<=1, busy<=0; go to IDLE.
- Latency: fixed WIDTH+2 edges for all operands, including special cases.
  - Accept at edge E0; valid is visible after edge E(WIDTH+1), i.e. 34 cycles for WIDTH=32.
- valid lasts exactly one cycle; it is cleared at the next edge.
- quotient, remainder and div_by_zero hold until the next FIX.
- start while busy=1 is ignored; it is not queued.
- start in the cycle where valid=1 is accepted, because the state is already IDLE.
- Width rules: the partial remainder is WIDTH+1 bits internally. Negation is modulo 2^WIDTH.

Decomposition:
- Shared package alu_div_pkg: state enum (IDLE/CALC/FIX), DIV_WIDTH=32, DIV_LATENCY=DIV_WIDTH+2, constants DIV_ALL_ONES and DIV_INT_MIN.
- One natural sub-module: div_restoring_step. It is purely combinational. Inputs are rem, q and the divisor magnitude; outputs are next_rem and next_q. It is instantiated once inside the sequential wrapper.

Test Plan:
- Unsigned 100/7, is_signed=0 -> quotient=14, remainder=2, div_by_zero=0; valid exactly 34 cycles after the start edge, busy high for 33 cycles.
- Signed -7/2 (0xFFFFFFF9, 0x2), is_signed=1 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); 7/-2 -> 0xFFFFFFFD, 1.
- Divide by zero: DIVU 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; DIV -5/0 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFFB, div_by_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF, is_signed=1 -> quotient=0x80000000, remainder=0; same operands with is_signed=0 -> quotient=0, remainder=0x80000000.
- Handshake: start again 10 cycles into an operation -> ignored, the first result is unchanged. start asserted during the valid cycle -> a new operation is accepted, with its valid 34 cycles later.
- Reset at cycle 15 of an operation -> all outputs 0 at the next edge, no valid pulse. A subsequent 0xFFFFFFFF/1 unsigned -> quotient=0xFFFFFFFF, remainder=0.

Source files
------------

// File: rtl/alu_div_pkg.sv
// Shared types and constants for the iterative M-extension divider.
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN  = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_restoring_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_q
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The remainder stays below the divisor, so the WIDTH+1 bit trial never wraps into its sign bit.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_mag};
    if (!trial[WIDTH]) begin
      next_rem = trial[WIDTH-1:0];
      next_q   = {q[WIDTH-2:0], 1'b1};
    end else begin
      next_rem = shifted[WIDTH-1:0];
      next_q   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_iterative.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU with start/busy/valid handshake, WIDTH+2 cycle latency.
module divider_iterative
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             valid,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg_mod(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic                    sgn);
    return (sgn && (x < 0)) ? neg_mod(x) : x;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             load_op, step_en, fix_en;

  logic signed [WIDTH-1:0] dividend_s, divisor_s;
  logic [WIDTH-1:0]        dividend_q, divisor_mag, q_q, rem_q;
  logic [WIDTH-1:0]        next_q, next_rem;
  logic                    neg_q, neg_r, dz, ovf;

  assign dividend_s = dividend;
  assign divisor_s  = divisor;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt == LAST_CNT) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_op = (state_q == IDLE) && start;
    step_en = (state_q == CALC);
    fix_en  = (state_q == FIX);
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (load_op) cnt <= '0;
    else if (step_en) cnt <= cnt + 1'b1;
  end

  // Operand capture and iteration state; control above guards their use, so no reset here.
  always_ff @(posedge clk) begin
    if (load_op) begin
      dividend_q  <= dividend;
      divisor_mag <= magnitude(divisor_s, is_signed);
      q_q         <= magnitude(dividend_s, is_signed);
      rem_q       <= '0;
      neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r       <= is_signed & dividend[WIDTH-1];
      dz          <= (divisor == '0);
      ovf         <= is_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);
    end else if (step_en) begin
      rem_q <= next_rem;
      q_q   <= next_q;
    end
  end

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q),
    .q          (q_q),
    .divisor_mag(divisor_mag),
    .next_rem   (next_rem),
    .next_q     (next_q)
  );

  // Sign fix-up and RISC-V special-case overrides land together on the FIX edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      valid       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid <= fix_en;
      if (load_op) busy <= 1'b1;
      if (fix_en) begin
        busy        <= 1'b0;
        div_by_zero <= dz;
        if (dz) begin
          quotient  <= ALL_ONES;
          remainder <= dividend_q;
        end else if (ovf) begin
          quotient  <= INT_MIN;
          remainder <= '0;
        end else begin
          quotient  <= neg_q ? neg_mod(q_q) : q_q;
          remainder <= neg_r ? neg_mod(rem_q) : rem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_iterative.sv
// Directed-vector bench for divider_iterative: results, special cases, latency and handshake.
module tb_divider_iterative;
  import alu_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        div_by_zero, valid, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  divider_iterative #(.WIDTH(DIV_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .valid      (valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a request at the falling edge, return #1 after the accepting edge with inputs scrambled.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int n, output int nbusy);
    n = 0; nbusy = 0;
    while (!valid && n < 100) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      n++;
    end
    check("valid_seen", {31'b0, valid}, 32'd1);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
  endtask

  logic [31:0] va [5] = '{32'hFFFFFFF9, 32'd5, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
  logic [31:0] vb [5] = '{32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic        vs [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] vq [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0};
  logic [31:0] vr [5] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB, 32'd0, 32'h80000000};
  logic        vz [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n, nb, seen;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // 100/7 unsigned with latency and busy duration
    launch(32'd100, 32'd7, 1'b0);
    check("accept_busy", {31'b0, busy}, 32'd1);
    wait_valid(n, nb);
    check("divu_latency", n + 1, DIV_LATENCY);
    check("divu_busy_cycles", nb, 32'd33);
    check("divu_q", quotient, 32'd14);
    check("divu_r", remainder, 32'd2);
    check("divu_dbz", {31'b0, div_by_zero}, 32'd0);

    // start during the valid cycle is accepted: 7 / -2 signed
    dividend = 32'd7; divisor = 32'hFFFFFFFE; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    check("valid_one_cycle", {31'b0, valid}, 32'd0);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("hold_q", quotient, 32'd14);
    wait_valid(n, nb);
    check("b2b_latency", n + 1, DIV_LATENCY);
    check("div_7_m2_q", quotient, 32'hFFFFFFFD);
    check("div_7_m2_r", remainder, 32'd1);

    for (int i = 0; i < 5; i++) begin
      launch(va[i], vb[i], vs[i]);
      wait_valid(n, nb);
      check($sformatf("vec%0d_latency", i), n + 1, DIV_LATENCY);
      check($sformatf("vec%0d_q", i), quotient, vq[i]);
      check($sformatf("vec%0d_r", i), remainder, vr[i]);
      check($sformatf("vec%0d_dbz", i), {31'b0, div_by_zero}, {31'b0, vz[i]});
    end

    // start while busy is ignored
    launch(32'd1000, 32'd10, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(n, nb);
    check("busy_start_latency", n + 11, DIV_LATENCY);
    check("busy_start_q", quotient, 32'd100);
    check("busy_start_r", remainder, 32'd0);
    count_valid(40, seen);
    check("busy_start_not_queued", seen, 32'd0);

    // reset at cycle 15 aborts the operation
    launch(32'h0000FFFF, 32'h10, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_valid", {31'b0, valid}, 32'd0);
    count_valid(40, seen);
    check("abort_no_valid", seen, 32'd0);

    launch(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_valid(n, nb);
    check("post_rst_latency", n + 1, DIV_LATENCY);
    check("post_rst_q", quotient, DIV_ALL_ONES);
    check("post_rst_r", remainder, 32'd0);
    check("post_rst_dbz", {31'b0, div_by_zero}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
